mem_stage: RTL and testbench

Memory stage of the pipelined LEGv8 datapath, directly downstream of `execute`. It holds the EX/MEM pipeline register and resolves taken branches from `zero_E`/`PCBranch_E`. It runs load/store accesses against a data memory with a req/ack handshake and stalls upstream stages while an access is outstanding. It delivers a registered MEM/WB bundle to writeback.

---
 rtl/mem_pkg.sv | 39 +++
 rtl/mem_watchdog.sv | 32 +++
 rtl/mem_stage.sv | 133 +++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the LEGv8 memory stage: FSM encoding, pipeline register layouts, defaults.
package mem_pkg;

  localparam int DATA_W          = 64;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              reg_write;
    logic              memto_reg;
    logic              zero;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_branch;
    logic [4:0]        write_reg;
  } exmem_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              memto_reg;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] read_data;
    logic [4:0]        write_reg;
  } memwb_t;

  function automatic logic is_mem_op(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting for a memory ack; flags expiry once TIMEOUT cycles pass unanswered.
module mem_watchdog
  import mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic busy,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = busy & ~ack & (count == CW'(TIMEOUT));

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (busy & ~ack & ~expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LEGv8 memory stage: EX/MEM register, branch resolve, req/ack data-memory access, MEM/WB register.
// Optional ack watchdog and sticky mem_err are compiled in with MEM_STAGE_TIMEOUT_EN.
module mem_stage
  import mem_pkg::*;
#(
  parameter int N       = DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_E,
  input  logic         memRead_E,
  input  logic         memWrite_E,
  input  logic         branch_E,
  input  logic         regWrite_E,
  input  logic         memtoReg_E,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic [4:0]   writeReg_E,
  output logic         stall_M,
  output logic         PCSrc_M,
  output logic [N-1:0] PCBranch_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata,
  output logic         wb_valid,
  output logic         wb_regWrite,
  output logic         wb_memtoReg,
  output logic [N-1:0] wb_aluResult,
  output logic [N-1:0] wb_readData,
  output logic [4:0]   wb_writeReg,
  output logic         mem_err
);

  mem_state_t state, state_d;
  exmem_t     ex_m, ex_d;
  memwb_t     wb_q;
  logic       op_e, capture, load_done, expired;

  assign op_e      = is_mem_op(valid_E, memRead_E, memWrite_E);
  // Ack is only meaningful while an access is outstanding; in IDLE it is ignored.
  assign stall_M   = (state == WAIT) & ~mem_ack & ~expired;
  assign capture   = ~stall_M;
  assign load_done = (state == WAIT) & mem_ack & ex_m.valid & ex_m.mem_read;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    ex_d            = '0;
    ex_d.valid      = valid_E;
    ex_d.mem_read   = memRead_E;
    ex_d.mem_write  = memWrite_E;
    ex_d.branch     = branch_E;
    ex_d.reg_write  = regWrite_E;
    ex_d.memto_reg  = memtoReg_E;
    ex_d.zero       = zero_E;
    ex_d.alu_result = aluResult_E;
    ex_d.write_data = writeData_E;
    ex_d.pc_branch  = PCBranch_E;
    ex_d.write_reg  = writeReg_E;
  end

  // Whenever the stage advances, the new state is decided by what is being captured.
  always_comb begin
    state_d = state;
    if (capture) state_d = op_e ? WAIT : IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ex_m  <= '0;
      wb_q  <= '0;
    end else begin
      state <= state_d;
      if (capture) begin
        ex_m           <= ex_d;
        wb_q.valid     <= ex_m.valid;
        wb_q.reg_write <= ex_m.reg_write & ~expired;
        wb_q.memto_reg <= ex_m.memto_reg;
        wb_q.alu_result <= ex_m.alu_result;
        wb_q.write_reg <= ex_m.write_reg;
        if (load_done) wb_q.read_data <= mem_rdata;
      end else begin
        wb_q.valid <= 1'b0;
      end
    end
  end

  assign PCSrc_M      = ex_m.valid & ex_m.branch & ex_m.zero;
  assign PCBranch_M   = ex_m.pc_branch;
  assign mem_req      = (state == WAIT);
  assign mem_we       = ex_m.mem_write;
  assign mem_addr     = ex_m.alu_result;
  assign mem_wdata    = ex_m.write_data;

  assign wb_valid     = wb_q.valid;
  assign wb_regWrite  = wb_q.reg_write;
  assign wb_memtoReg  = wb_q.memto_reg;
  assign wb_aluResult = wb_q.alu_result;
  assign wb_readData  = wb_q.read_data;
  assign wb_writeReg  = wb_q.write_reg;

`ifdef MEM_STAGE_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (capture & op_e),
    .busy    (state == WAIT),
    .ack     (mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (expired) err_q <= 1'b1;
  end

  assign mem_err = err_q;
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
  assign expired        = 1'b0;
  assign mem_err        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed stimulus pushes expected retirements, a monitor pops them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_E, memRead_E, memWrite_E, branch_E, regWrite_E, memtoReg_E, zero_E;
  logic [63:0] aluResult_E, writeData_E, PCBranch_E;
  logic [4:0]  writeReg_E;
  logic        stall_M, PCSrc_M, mem_req, mem_we, mem_ack;
  logic [63:0] PCBranch_M, mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, wb_regWrite, wb_memtoReg, mem_err;
  logic [63:0] wb_aluResult, wb_readData;
  logic [4:0]  wb_writeReg;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] rdata;
    bit          chk_rdata;
    logic [4:0]  wreg;
    logic        regw;
    logic        m2r;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic ack_en, ack_force;
  int   ack_delay, wait_cnt;

  mem_stage #(.N(64), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .valid_E(valid_E), .memRead_E(memRead_E), .memWrite_E(memWrite_E),
    .branch_E(branch_E), .regWrite_E(regWrite_E), .memtoReg_E(memtoReg_E),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .writeReg_E(writeReg_E),
    .stall_M(stall_M), .PCSrc_M(PCSrc_M), .PCBranch_M(PCBranch_M),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_memtoReg(wb_memtoReg),
    .wb_aluResult(wb_aluResult), .wb_readData(wb_readData), .wb_writeReg(wb_writeReg),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Memory responder: acks ack_delay cycles after a request appears (0 = same cycle).
  assign mem_ack = ack_force | (mem_req & ack_en & (wait_cnt >= ack_delay));

  always @(posedge clk) begin
    if (reset || !mem_req || mem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, rd, wr, br, rw, m2r, z,
                       input logic [63:0] alu, wd, pcb, input logic [4:0] wreg);
    valid_E = v;  memRead_E = rd; memWrite_E = wr; branch_E = br;
    regWrite_E = rw; memtoReg_E = m2r; zero_E = z;
    aluResult_E = alu; writeData_E = wd; PCBranch_E = pcb; writeReg_E = wreg;
  endtask

  task automatic bubble();
    drive(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 64'h0, 5'd0);
  endtask

  task automatic expect_retire(input logic [63:0] alu, input logic [63:0] rdata, input bit chk,
                               input logic [4:0] wreg, input logic regw, input logic m2r);
    exp_t e;
    e.alu = alu; e.rdata = rdata; e.chk_rdata = chk; e.wreg = wreg; e.regw = regw; e.m2r = m2r;
    sb.push_back(e);
  endtask

  // Monitor: every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && wb_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_aluResult", wb_aluResult, e.alu);
        check("wb_writeReg", 64'(wb_writeReg), 64'(e.wreg));
        check("wb_regWrite", 64'(wb_regWrite), 64'(e.regw));
        check("wb_memtoReg", 64'(wb_memtoReg), 64'(e.m2r));
        if (e.chk_rdata) check("wb_readData", wb_readData, e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int n;
    reset = 1'b1; ack_en = 1'b1; ack_force = 1'b0; ack_delay = 0; mem_rdata = 64'h0;
    bubble();
    step(); step();
    reset = 1'b0;

    // Reset state
    check("rst_stall", 64'(stall_M), 64'd0);
    check("rst_pcsrc", 64'(PCSrc_M), 64'd0);
    check("rst_pcbranch", PCBranch_M, 64'h0);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_alu", wb_aluResult, 64'h0);
    check("rst_mem_err", 64'(mem_err), 64'd0);

    // Non-memory op: two edges to writeback, no stall
    drive(1, 0, 0, 0, 1, 0, 0, 64'h10, 64'h0, 64'h0, 5'd5);
    expect_retire(64'h10, 64'h0, 0, 5'd5, 1, 0);
    step();
    check("t1_stall_a", 64'(stall_M), 64'd0);
    check("t1_mem_req", 64'(mem_req), 64'd0);
    bubble();
    step();
    check("t1_stall_b", 64'(stall_M), 64'd0);
    check("t1_wb_valid", 64'(wb_valid), 64'd1);
    step();

    // Branch taken, then not taken
    drive(1, 0, 0, 1, 0, 0, 1, 64'h0, 64'h0, 64'h40, 5'd0);
    expect_retire(64'h0, 64'h0, 0, 5'd0, 0, 0);
    step();
    check("t2_pcsrc_taken", 64'(PCSrc_M), 64'd1);
    check("t2_pcbranch", PCBranch_M, 64'h40);
    bubble();
    step();
    check("t2_pcsrc_one_cycle", 64'(PCSrc_M), 64'd0);
    drive(1, 0, 0, 1, 0, 0, 0, 64'h0, 64'h0, 64'h44, 5'd0);
    expect_retire(64'h0, 64'h0, 0, 5'd0, 0, 0);
    step();
    check("t2_pcsrc_not_taken", 64'(PCSrc_M), 64'd0);
    bubble();
    step(); step();

    // Load at 0x80 acked after 3 cycles
    ack_delay = 3; mem_rdata = 64'hDEAD;
    drive(1, 1, 0, 0, 1, 1, 0, 64'h80, 64'h0, 64'h0, 5'd9);
    expect_retire(64'h80, 64'hDEAD, 1, 5'd9, 1, 1);
    step();
    bubble();
    check("t3_mem_req", 64'(mem_req), 64'd1);
    check("t3_mem_addr", mem_addr, 64'h80);
    check("t3_mem_we", 64'(mem_we), 64'd0);
    n = 0;
    for (int i = 0; i < 20 && stall_M; i++) begin
      n++;
      step();
    end
    check("t3_stall_cycles", 64'(n), 64'd3);
    step();
    check("t3_wb_valid", 64'(wb_valid), 64'd1);
    check("t3_mem_req_done", 64'(mem_req), 64'd0);
    mem_rdata = 64'h0;
    step();

    // Back-to-back zero-wait stores
    ack_delay = 0;
    drive(1, 0, 1, 0, 0, 0, 0, 64'h8, 64'hAA, 64'h0, 5'd0);
    expect_retire(64'h8, 64'h0, 0, 5'd0, 0, 0);
    step();
    drive(1, 0, 1, 0, 0, 0, 0, 64'h10, 64'hBB, 64'h0, 5'd0);
    expect_retire(64'h10, 64'h0, 0, 5'd0, 0, 0);
    check("t4_req_first", 64'(mem_req), 64'd1);
    check("t4_we_first", 64'(mem_we), 64'd1);
    check("t4_addr_first", mem_addr, 64'h8);
    check("t4_wdata_first", mem_wdata, 64'hAA);
    check("t4_stall_first", 64'(stall_M), 64'd0);
    step();
    bubble();
    check("t4_req_second", 64'(mem_req), 64'd1);
    check("t4_we_second", 64'(mem_we), 64'd1);
    check("t4_addr_second", mem_addr, 64'h10);
    check("t4_wdata_second", mem_wdata, 64'hBB);
    check("t4_stall_second", 64'(stall_M), 64'd0);
    step();
    check("t4_req_idle", 64'(mem_req), 64'd0);
    step();

    // Reset during WAIT, then a late ack
    ack_en = 1'b0;
    drive(1, 1, 0, 0, 1, 1, 0, 64'h100, 64'h0, 64'h0, 5'd7);
    step();
    bubble();
    check("t5_req_wait", 64'(mem_req), 64'd1);
    check("t5_stall_wait", 64'(stall_M), 64'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ack_force = 1'b1; mem_rdata = 64'hBEEF;
    check("t5_req_after_reset", 64'(mem_req), 64'd0);
    check("t5_wb_valid_after_reset", 64'(wb_valid), 64'd0);
    check("t5_stall_after_reset", 64'(stall_M), 64'd0);
    step();
    check("t5_req_late_ack", 64'(mem_req), 64'd0);
    check("t5_wb_valid_late_ack", 64'(wb_valid), 64'd0);
    check("t5_readdata_untouched", wb_readData, 64'h0);
    ack_force = 1'b0; mem_rdata = 64'h0;
    step();

`ifdef MEM_STAGE_TIMEOUT_EN
    // Load with no ack: watchdog aborts after TIMEOUT=4 cycles
    drive(1, 1, 0, 0, 1, 1, 0, 64'h200, 64'h0, 64'h0, 5'd3);
    expect_retire(64'h200, 64'h0, 0, 5'd3, 0, 1);
    step();
    bubble();
    n = 0;
    for (int i = 0; i < 20 && stall_M; i++) begin
      n++;
      step();
    end
    check("t6_stall_cycles", 64'(n), 64'd4);
    step();
    check("t6_mem_err_set", 64'(mem_err), 64'd1);
    check("t6_req_dropped", 64'(mem_req), 64'd0);
    check("t6_stall_released", 64'(stall_M), 64'd0);
    step(); step(); step();
    check("t6_mem_err_sticky", 64'(mem_err), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_mem_err_cleared", 64'(mem_err), 64'd0);
    step();
`endif
    ack_en = 1'b1;

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
